// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared word width, loader state type and boot image for instr_mem
package instr_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } ld_state_e;

  localparam int BOOT_LEN = 4;
  localparam logic [WORD_W-1:0] BOOT_IMAGE [0:BOOT_LEN-1] = '{
    32'h00000013,
    32'h00100093,
    32'h00208113,
    32'h0000006F
  };

  // Words past the end of the image boot as zero.
  function automatic logic [WORD_W-1:0] boot_word(input int idx);
    logic [WORD_W-1:0] w;
    w = '0;
    if (idx >= 0 && idx < BOOT_LEN) w = BOOT_IMAGE[idx];
    return w;
  endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - RUN/LOAD session control: handshake, write pointer, word count
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ld_start,
  input  logic                           ld_valid,
  input  logic                           ld_last,
  output logic                           ld_ready,
  output logic                           ld_done,
  output logic [$clog2(DEPTH_WORDS):0]   ld_count,
  output logic                           busy,
  output logic                           wr_en,
  output logic [$clog2(DEPTH_WORDS)-1:0] wr_ptr
);

  localparam int PTR_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = PTR_W + 1;

  ld_state_e        state, state_nx;
  logic [PTR_W-1:0] ptr;
  logic             in_load;
  logic             xfer;
  logic             final_xfer;

  assign in_load    = (state == ST_LOAD);
  assign xfer       = ld_valid && in_load;
  // The session closes on the tagged last word or when the array is full.
  assign final_xfer = xfer && (ld_last || ptr == PTR_W'(DEPTH_WORDS - 1));
  assign wr_en      = xfer;
  assign wr_ptr     = ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_RUN: begin
        if (ld_start) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (final_xfer) state_nx = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      ld_count <= '0;
      ld_done  <= 1'b0;
    end else begin
      ld_done <= final_xfer;
      if (!in_load && ld_start) begin
        ptr      <= '0;
        ld_count <= '0;
      end else if (xfer) begin
        ptr      <= ptr + PTR_W'(1);
        ld_count <= ld_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - byte-addressed instruction memory with streamed word loader
// Define BOOT_IMAGE_EN to preload the package boot image on reset.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32,
  parameter int LITTLE_END  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_start,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [WORD_W-1:0]            ld_data,
  input  logic                         ld_last,
  output logic                         ld_done,
  output logic [$clog2(DEPTH_WORDS):0] ld_count,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [WORD_W-1:0]            rd_data,
  output logic                         rd_valid,
  output logic                         rd_err,
  output logic                         busy
);

  localparam int PTR_W = $clog2(DEPTH_WORDS);
  localparam int BYTES = 4 * DEPTH_WORDS;

  logic [7:0]        mem [0:BYTES-1];
  logic              wr_en;
  logic [PTR_W-1:0]  wr_ptr;
  logic [WORD_W-1:0] rd_word;
  logic              rd_bad;

  instr_mem_loader #(.DEPTH_WORDS(DEPTH_WORDS)) u_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_count (ld_count),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_ptr   (wr_ptr)
  );

  // Byte b of a word sits at address offset b.
  function automatic logic [7:0] lane(input logic [WORD_W-1:0] w, input int b);
    return (LITTLE_END != 0) ? w[8*b +: 8] : w[8*(3-b) +: 8];
  endfunction

`ifdef BOOT_IMAGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH_WORDS; w++)
        for (int b = 0; b < 4; b++)
          mem[{PTR_W'(w), 2'(b)}] <= lane(boot_word(w), b);
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        mem[{wr_ptr, 2'(b)}] <= lane(ld_data, b);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        mem[{wr_ptr, 2'(b)}] <= lane(ld_data, b);
    end
  end
`endif

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < 4; b++)
      rd_word[((LITTLE_END != 0) ? 8*b : 8*(3-b)) +: 8] = mem[{rd_addr[PTR_W+1:2], 2'(b)}];
  end

  // Reads are refused while a load is rewriting the array.
  assign rd_bad = (rd_addr[1:0] != 2'b00) || (rd_addr >= ADDR_W'(BYTES)) || busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && rd_bad;
      rd_data  <= (rd_en && !rd_bad) ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_instr_mem.sv
// tb/tb_instr_mem.sv - scoreboard bench: instr_mem with 64 LE words and 4 BE words
module tb_instr_mem;
  import instr_mem_pkg::*;

  typedef struct packed {
    int          stamp;
    logic        err;
    logic [31:0] data;
    logic        known;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst_n    [2] = '{1'b0, 1'b0};
  logic        ld_start [2] = '{1'b0, 1'b0};
  logic        ld_valid [2] = '{1'b0, 1'b0};
  logic        ld_last  [2] = '{1'b0, 1'b0};
  logic        rd_en    [2] = '{1'b0, 1'b0};
  logic [31:0] ld_data  [2] = '{32'h0, 32'h0};
  logic [31:0] rd_addr  [2] = '{32'h0, 32'h0};
  logic        ld_ready [2];
  logic        ld_done  [2];
  logic        rd_valid [2];
  logic        rd_err   [2];
  logic        busy     [2];
  logic [31:0] rd_data  [2];
  logic [6:0]  ld_count0;
  logic [2:0]  ld_count1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  rd_exp_t     sbq [2][$];
  logic [31:0] fixed_w [$];
  bit   [31:0] mw [2][64];
  bit          mk [2][64];
  bit          in_load [2] = '{1'b0, 1'b0};
  int          dep [2] = '{64, 4};
  bit          le  [2] = '{1'b1, 1'b0};

  instr_mem #(.DEPTH_WORDS(64), .ADDR_W(32), .LITTLE_END(1)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .ld_start(ld_start[0]), .ld_valid(ld_valid[0]),
    .ld_ready(ld_ready[0]), .ld_data(ld_data[0]), .ld_last(ld_last[0]), .ld_done(ld_done[0]),
    .ld_count(ld_count0), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .rd_valid(rd_valid[0]), .rd_err(rd_err[0]), .busy(busy[0])
  );

  instr_mem #(.DEPTH_WORDS(4), .ADDR_W(32), .LITTLE_END(0)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .ld_start(ld_start[1]), .ld_valid(ld_valid[1]),
    .ld_ready(ld_ready[1]), .ld_data(ld_data[1]), .ld_last(ld_last[1]), .ld_done(ld_done[1]),
    .ld_count(ld_count1), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .rd_valid(rd_valid[1]), .rd_err(rd_err[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int cnt(input int i);
    return (i == 0) ? int'(ld_count0) : int'(ld_count1);
  endfunction

  task automatic init_model(input int i);
    for (int w = 0; w < 64; w++) begin
`ifdef BOOT_IMAGE_EN
      mw[i][w] = (w < dep[i]) ? boot_word(w) : 32'h0;
      mk[i][w] = 1'b1;
`else
      mw[i][w] = 32'h0;
      mk[i][w] = 1'b0;
`endif
    end
  endtask

  // Expected response follows directly from the address rules and the word model.
  task automatic push_read(input int i, input logic [31:0] addr);
    rd_exp_t e;
    e.stamp = cyc;
    e.err   = (addr[1:0] != 2'b00) || (addr >= 32'(4 * dep[i])) || in_load[i];
    e.data  = 32'h0;
    e.known = 1'b1;
    if (!e.err) begin
      e.data  = mw[i][addr >> 2];
      e.known = mk[i][addr >> 2];
    end
    sbq[i].push_back(e);
  endtask

  task automatic do_read(input int i, input logic [31:0] addr);
    rd_en[i]   = 1'b1;
    rd_addr[i] = addr;
    push_read(i, addr);
    tick();
    rd_en[i] = 1'b0;
  endtask

  task automatic do_load(input int i, input int n, input bit use_last, input int stall_at,
                         input int abort_at, input int rd_start);
    int k;
    bit open;
    bit fin;
    logic [31:0] w;
    k = 0;
    open = 1'b1;
    ld_start[i] = 1'b1;
    if (rd_start >= 0) begin
      rd_en[i]   = 1'b1;
      rd_addr[i] = 32'(rd_start);
      push_read(i, 32'(rd_start));
    end
    tick();
    ld_start[i] = 1'b0;
    rd_en[i]    = 1'b0;
    in_load[i]  = 1'b1;
    chk("busy_enter", 32'(busy[i]), 32'd1);
    chk("count_clear", 32'(cnt(i)), 32'd0);
    for (int j = 0; j < n; j++) begin
      if (j == abort_at) begin
        ld_valid[i] = 1'b0;
        ld_last[i]  = 1'b0;
        rst_n[i]    = 1'b0;
        #1;
        chk("rst_busy", 32'(busy[i]), 32'd0);
        chk("rst_ready", 32'(ld_ready[i]), 32'd0);
        chk("rst_done", 32'(ld_done[i]), 32'd0);
        chk("rst_count", 32'(cnt(i)), 32'd0);
        tick();
        tick();
        rst_n[i]   = 1'b1;
        in_load[i] = 1'b0;
`ifdef BOOT_IMAGE_EN
        init_model(i);
`endif
        tick();
        chk("abort_done", 32'(ld_done[i]), 32'd0);
        chk("abort_busy", 32'(busy[i]), 32'd0);
        return;
      end
      if (j == stall_at) begin
        for (int s = 0; s < 3; s++) begin
          ld_valid[i] = 1'b0;
          ld_last[i]  = 1'b0;
          ld_start[i] = (s == 1);
          if (s == 0) begin
            rd_en[i]   = 1'b1;
            rd_addr[i] = 32'h0;
            push_read(i, 32'h0);
          end
          tick();
          rd_en[i] = 1'b0;
          chk("stall_count", 32'(cnt(i)), 32'(k));
          chk("stall_busy", 32'(busy[i]), 32'd1);
        end
        ld_start[i] = 1'b0;
      end
      w = (fixed_w.size() != 0) ? fixed_w.pop_front() : $urandom;
      ld_valid[i] = 1'b1;
      ld_data[i]  = w;
      ld_last[i]  = use_last && (j == n - 1);
      chk("ld_ready", 32'(ld_ready[i]), 32'(open));
      fin = 1'b0;
      if (open) begin
        mw[i][k] = w;
        mk[i][k] = 1'b1;
        k++;
        if (ld_last[i] || k == dep[i]) begin
          open = 1'b0;
          fin  = 1'b1;
        end
      end
      tick();
      in_load[i] = open;
      chk("ld_done", 32'(ld_done[i]), 32'(fin));
      chk("busy", 32'(busy[i]), 32'(open));
    end
    ld_valid[i] = 1'b0;
    ld_last[i]  = 1'b0;
    tick();
    chk("done_once", 32'(ld_done[i]), 32'd0);
    chk("ld_count", 32'(cnt(i)), 32'(k));
  endtask

  always @(negedge clk) begin
    rd_exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (sbq[i].size() != 0 && sbq[i][0].stamp == cyc - 1) begin
        e = sbq[i].pop_front();
        chk("rd_valid", 32'(rd_valid[i]), 32'd1);
        chk("rd_err", 32'(rd_err[i]), 32'(e.err));
        if (e.known) chk("rd_data", rd_data[i], e.data);
      end else begin
        chk("rd_valid_idle", 32'(rd_valid[i]), 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int i;
    int n;
    init_model(0);
    init_model(1);
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", 32'(busy[d]), 32'd0);
      chk("reset_ready", 32'(ld_ready[d]), 32'd0);
      chk("reset_done", 32'(ld_done[d]), 32'd0);
      chk("reset_rd_valid", 32'(rd_valid[d]), 32'd0);
      chk("reset_rd_err", 32'(rd_err[d]), 32'd0);
      chk("reset_rd_data", rd_data[d], 32'd0);
      chk("reset_count", 32'(cnt(d)), 32'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    tick();

    fixed_w.push_back(32'h80010028);
    fixed_w.push_back(32'h80020014);
    fixed_w.push_back(32'hAC020002);
    do_load(0, 3, 1'b1, -1, -1, -1);
    do_read(0, 32'h8);
    do_read(0, 32'h0);
    do_read(0, 32'h4);

    for (int d = 0; d < 2; d++) begin
      fixed_w.push_back(32'h11223344);
      do_load(d, 1, 1'b1, -1, -1, -1);
      do_read(d, 32'h0);
    end
    chk("byte0_le", 32'(u0.mem[0]), le[0] ? (mw[0][0] & 32'hFF) : (mw[0][0] >> 24));
    chk("byte0_be", 32'(u1.mem[0]), le[1] ? (mw[1][0] & 32'hFF) : (mw[1][0] >> 24));

    do_read(0, 32'h6);
    do_read(0, 32'h100);
    do_read(1, 32'h10);

    do_load(1, 5, 1'b0, -1, -1, -1);
    for (int w = 0; w < 4; w++) do_read(1, 32'(4 * w));

    do_load(0, 6, 1'b1, 3, -1, -1);
    do_load(0, 2, 1'b1, -1, -1, 8);
    for (int w = 0; w < 6; w++) do_read(0, 32'(4 * w));

    do_load(0, 5, 1'b0, -1, 2, -1);
    do_read(0, 32'h0);
    do_read(0, 32'h4);

    for (int it = 0; it < 30; it++) begin
      i = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          n = $urandom_range(1, dep[i]);
          do_load(i, n, 1'b1, $urandom_range(0, n), -1,
                  ($urandom_range(0, 1) == 1) ? 4 * $urandom_range(0, dep[i] - 1) : -1);
        end else begin
          do_load(i, dep[i] + 1, 1'b0, $urandom_range(0, dep[i]), -1, -1);
        end
      end else begin
        for (int r = 0; r < 4; r++) begin
          case ($urandom_range(0, 3))
            0, 1:    a = 32'(4 * $urandom_range(0, dep[i] - 1));
            2:       a = 32'(4 * $urandom_range(0, dep[i] - 1) + $urandom_range(1, 3));
            default: a = 32'(4 * dep[i] + 4 * $urandom_range(0, 15) + $urandom_range(0, 3));
          endcase
          do_read(i, a);
        end
      end
    end

    repeat (3) tick();
    chk("sb_drain0", 32'(sbq[0].size()), 32'd0);
    chk("sb_drain1", 32'(sbq[1].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning instruction words stored; legal range 4..1024.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter LITTLE_END, default 1, meaning byte order: 1 puts word bits 7:0 at byte addr+0; 0 puts bits 31:24 at addr+0.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ld_start, input, 1, request to start a load session.
REQ-007 SHALL have ports ld_valid (input, 1), ld_ready (output, 1), ld_data (input, 32), ld_last (input, 1): word-load handshake.
REQ-008 SHALL have ports ld_done (output, 1, one-cycle pulse at end of load) and ld_count (output, clog2(DEPTH_WORDS)+1, words written in the current or last session).
REQ-009 SHALL have ports rd_en (input, 1), rd_addr (input, ADDR_W), rd_data (output, 32), rd_valid (output, 1), rd_err (output, 1).
REQ-010 SHALL have port busy (output, 1), high while in LOAD.

Function
REQ-011 SHALL store DEPTH_WORDS*4 bytes; each word occupies 4 consecutive byte addresses ordered per LITTLE_END.
REQ-012 SHALL implement states RUN and LOAD; RUN -> LOAD on ld_start; LOAD -> RUN on the accepted ld_last word or on acceptance of word DEPTH_WORDS-1, whichever comes first.
REQ-013 SHALL drive ld_ready=1 only in LOAD; a transfer occurs when ld_valid && ld_ready.
REQ-014 SHALL write each transferred word at byte address 4*ptr, where ptr starts at 0 on entry to LOAD and increments by 1 per transfer.
REQ-015 SHALL pulse ld_done for exactly one cycle, in the cycle after the final transfer, when the state is back in RUN.
REQ-016 SHALL ignore ld_start while in LOAD.
REQ-017 SHALL, for rd_en in RUN, present rd_data and rd_valid=1 one cycle later (latency 1); rd_valid is low when no read was issued.
REQ-018 SHALL flag rd_err=1 with rd_valid and force rd_data=0 when rd_addr[1:0]!=0, rd_addr>=4*DEPTH_WORDS, or the read is issued in LOAD.
REQ-019 SHALL service a read issued in the same cycle as ld_start from pre-load contents, without error.
REQ-020 SHALL return the newly written word for a read in RUN issued any cycle after ld_done.
REQ-021 SHALL hold ld_count after LOAD exits, until the next ld_start clears it to 0.

Reset
REQ-022 SHALL, while rst_n=0, force state RUN, ptr=0, ld_count=0, and ld_ready, ld_done, rd_valid, rd_err, busy=0, rd_data=0.
REQ-023 SHALL on reset during LOAD abandon the session, keep already-written words (unless REQ-024 applies), and pulse no ld_done.

Configuration
REQ-024 SHALL, with BOOT_IMAGE_EN defined, initialise memory on reset from the package boot image; all remaining words are 0.
REQ-025 SHALL, without BOOT_IMAGE_EN, leave memory contents unaffected by reset (undefined after power-up) and infer plain RAM.

Structure
REQ-026 SHALL place the word-width constant, the state enum, and the boot-image word array with its length in package instr_mem_pkg.
REQ-027 SHALL use one sub-module, instr_mem_loader, holding the RUN/LOAD FSM, ptr, ld_count and handshake; the byte array and read path stay in instr_mem.

Verification
REQ-028 SHALL cover: load 3 words 0x80010028, 0x80020014, 0xAC020002 with ld_last on the third -> ld_done pulse, ld_count=3; read addr 0x8 -> rd_data=0xAC020002, rd_err=0.
REQ-029 SHALL cover: LITTLE_END=1, word 0x11223344 at addr 0 -> byte 0 holds 0x44; LITTLE_END=0 -> byte 0 holds 0x11; rd_data=0x11223344 in both cases.
REQ-030 SHALL cover: read addr 0x6 (misaligned) or 0x100 with DEPTH_WORDS=64 -> rd_valid=1, rd_err=1, rd_data=0.
REQ-031 SHALL cover: load without ld_last, DEPTH_WORDS=4 -> LOAD exits after 4th transfer, ld_count=4; a 5th ld_valid is not accepted (ld_ready=0).
REQ-032 SHALL cover: assert rst_n=0 after 2 of 5 load words -> busy=0, no ld_done; without BOOT_IMAGE_EN the 2 words read back intact; with it, addr 0 returns boot image word 0.
REQ-033 SHALL cover: ld_valid stalled low for 3 cycles mid-session, plus ld_start asserted during LOAD -> ptr unchanged during the stall, session not restarted.
